seq_control: RTL
================

SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of cycles any memory access waits for mem_ack before it aborts.
REQ-002 Port clk, input, 1 bit: single clock, rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port run, input, 1 bit: start/continue execution.
REQ-005 Port mem_rdata, input, 16 bits: memory read data, valid with mem_ack.
REQ-006 Port mem_ack, input, 1 bit: memory completion, one-cycle pulse.
REQ-007 Port z_flag, input, 1 bit: the rx operand equals zero.
REQ-008 Port mem_rd_req, output, 1 bit: memory read request, held until ack.
REQ-009 Port mem_wr_req, output, 1 bit: memory write request, held until ack.
REQ-010 Port addr_sel, output, 1 bit: memory address source, 0 = PC, 1 = ry.
REQ-011 Port pc_inc, output, 1 bit: PC += 1, one-cycle pulse.
REQ-012 Port pc_load, output, 1 bit: PC += sign-extended imm9, one-cycle pulse.
REQ-013 Port imm9, output, 9 bits: IR[8:0], fed to sign_extender.
REQ-014 Port imm_sel, output, 1 bit: ALU B source, 1 = sign-extended imm9, 0 = ry.
REQ-015 Port alu_op, output, 2 bits: 00 pass-B, 01 add, 10 sub.
REQ-016 Port rf_we, output, 1 bit: register-file write, one-cycle pulse.
REQ-017 Port wb_sel, output, 1 bit: write-back source, 0 = ALU, 1 = mem_rdata.
REQ-018 Port rx, output, 3 bits: IR[11:9], the destination and A-port address.
REQ-019 Port ry, output, 3 bits: IR[8:6], the B-port address.
REQ-020 Port halted, output, 1 bit: the block is in the HALT state.
REQ-021 Port fault, output, 1 bit: sticky illegal-opcode or timeout flag.
REQ-022 Port instr_cnt, output, 16 bits: count of retired instructions, wraps.

Function
REQ-023 Encoding: opcode IR[15:12]; 0 MV, 1 MVI, 2 ADD, 3 SUB, 4 LD, 5 ST, 6 BEQZ, 15 HALT; all other opcodes are illegal.
REQ-024 States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
REQ-025 IDLE: all strobes low; go to FETCH on the first clock edge with run=1.
REQ-026 FETCH: mem_rd_req=1, addr_sel=0.
REQ-027 FETCH on mem_ack: load IR from mem_rdata, pulse pc_inc, go to DECODE.
REQ-028 DECODE: one cycle, no strobes, always goes to EXEC.
REQ-029 EXEC for MV/MVI/ADD/SUB: rf_we=1, wb_sel=0, imm_sel=1 for MVI and 0 otherwise, alu_op 00/00/01/10, retire.
REQ-030 EXEC for LD/ST: no strobes, go to MEM.
REQ-031 EXEC for BEQZ: pc_load=1 only if z_flag=1, retire.
REQ-032 EXEC for HALT: retire, go to HALT.
REQ-033 EXEC for an illegal opcode: set fault, do not retire, go to HALT.
REQ-034 Retire means: instr_cnt increments by 1 in that cycle, and the next state is FETCH if run=1, else IDLE.
REQ-035 MEM: addr_sel=1; mem_rd_req=1 for LD, mem_wr_req=1 for ST.
REQ-036 MEM for LD on ack: rf_we=1, wb_sel=1 in the ack cycle, retire.
REQ-037 MEM for ST on ack: retire.
REQ-038 Request outputs stay asserted, with addr_sel stable, until the ack cycle and drop the cycle after it.
REQ-039 mem_ack outside FETCH/MEM is ignored.
REQ-040 A wait counter clears on entry to FETCH/MEM; when it reaches MEM_TIMEOUT with no ack: drop the request, set fault, go to HALT, no retire.
REQ-041 HALT: halted=1; stay while run=1; go to IDLE when run=0.
REQ-042 fault clears only by reset or by an IDLE to FETCH transition.
REQ-043 run=0 mid-instruction does not abort; the instruction completes and the FSM then enters IDLE.
REQ-044 Latency, with ack in the first request cycle: ALU/BEQZ/HALT = 3 cycles; LD/ST = 4 cycles.
REQ-045 imm9, rx and ry are combinational from IR; IR changes only on a fetch ack.

Reset
REQ-046 rst_n=0 immediately forces IDLE, IR=0, instr_cnt=0, fault=0, wait counter=0, and all outputs 0.
REQ-047 Reset asserted mid-access drops mem_rd_req/mem_wr_req asynchronously.
REQ-048 An ack arriving during or after reset, before the next fetch, is ignored.
REQ-049 Leaving reset requires run=1 to begin fetching.

Verification
REQ-050 Fetch MVI r2,#0x1AE with ack after 2 wait cycles -> one pc_inc; rf_we in EXEC with imm_sel=1, alu_op=00, imm9=0x1AE, rx=2; instr_cnt=1.
REQ-051 Fetch BEQZ with imm9=0x1FF: z_flag=1 -> pc_load pulses once; z_flag=0 -> no pc_load; both cases retire.
REQ-052 LD r1,[r3] -> MEM shows mem_rd_req=1, addr_sel=1, ry=3; rf_we with wb_sel=1 exactly in the ack cycle; total 4 cycles.
REQ-053 Memory never acks in FETCH, MEM_TIMEOUT=15 -> request drops after 15 cycles, fault=1, halted=1, instr_cnt unchanged.
REQ-054 Opcode 0x9 -> fault=1, then HALT; run=0 -> IDLE; run=1 -> fault clears and fetching restarts.
REQ-055 rst_n pulled low while mem_wr_req=1 in MEM -> request drops the same instant; all state returns to reset values; a late ack has no effect.

Source files
------------

// File: rtl/seq_control.sv
// Sequencer for a small 16-bit processor: fetches, decodes and steps each
// instruction through the datapath, with bounded memory waits and a sticky fault flag.
module seq_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        z_flag,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic        addr_sel,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [8:0]  imm9,
  output logic        imm_sel,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic        wb_sel,
  output logic [2:0]  rx,
  output logic [2:0]  ry,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] OP_MV   = 4'h0;
  localparam logic [3:0] OP_MVI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_BEQZ = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [3:0] opcode;
  logic       retire;
  logic       timeout;

  assign opcode    = ir_q[15:12];
  assign imm9      = ir_q[8:0];
  assign rx        = ir_q[11:9];
  assign ry        = ir_q[8:6];
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;
  assign instr_cnt = cnt_q;
  // Last permitted wait cycle: the request has then been up MEM_TIMEOUT cycles.
  assign timeout   = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    wait_d     = wait_q;
    retire     = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    addr_sel   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    imm_sel    = 1'b0;
    alu_op     = 2'b00;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;

    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (run) begin
          state_d = S_FETCH;
          fault_d = 1'b0;
        end
      end
      S_FETCH: begin
        mem_rd_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_MV:  begin rf_we = 1'b1; retire = 1'b1; end
          OP_MVI: begin rf_we = 1'b1; imm_sel = 1'b1; retire = 1'b1; end
          OP_ADD: begin rf_we = 1'b1; alu_op = 2'b01; retire = 1'b1; end
          OP_SUB: begin rf_we = 1'b1; alu_op = 2'b10; retire = 1'b1; end
          OP_LD, OP_ST: begin
            wait_d  = '0;
            state_d = S_MEM;
          end
          OP_BEQZ: begin pc_load = z_flag; retire = 1'b1; end
          OP_HALT: begin
            cnt_d   = cnt_q + 16'd1;
            state_d = S_HALT;
          end
          default: begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        addr_sel   = 1'b1;
        mem_rd_req = (opcode == OP_LD);
        mem_wr_req = (opcode != OP_LD);
        if (mem_ack) begin
          rf_we  = (opcode == OP_LD);
          wb_sel = (opcode == OP_LD);
          retire = 1'b1;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_HALT: begin
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Retirement overrides the next state chosen above and arms a fresh fetch wait.
    if (retire) begin
      cnt_d   = cnt_q + 16'd1;
      wait_d  = '0;
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

endmodule
